// File: rtl/snn_csr_pkg.sv
// Shared constants, state encoding and accumulator limits for the CSR
// row accumulator and the neuron update stage.
package snn_csr_pkg;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned W_W    = 8;
  localparam int unsigned IDX_W  = 10;
  localparam int unsigned ACC_W  = 16;
  localparam int unsigned N_IN   = 2 ** IDX_W;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W - 1) {1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W - 1) {1'b0}}};

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/csr_row_accumulator_if.sv
// Request, weight-memory and result signals of the CSR row accumulator.
// The slave modport is the accumulator; the master is its environment.
interface csr_row_accumulator_if;
  import snn_csr_pkg::*;

  logic                    start_valid;
  logic                    start_ready;
  logic [ADDR_W-1:0]       row_start;
  logic [ADDR_W:0]         row_end;
  logic signed [ACC_W-1:0] threshold;
  logic [N_IN-1:0]         in_spikes;

  logic [ADDR_W-1:0]       mem_addr;
  logic signed [W_W-1:0]   mem_weight;
  logic [IDX_W-1:0]        mem_index;

  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_sum;
  logic                    out_spike;
  logic                    busy;

  modport master (
    output start_valid,
    output row_start,
    output row_end,
    output threshold,
    output in_spikes,
    output mem_weight,
    output mem_index,
    output out_ready,
    input  start_ready,
    input  mem_addr,
    input  out_valid,
    input  out_sum,
    input  out_spike,
    input  busy
  );

  modport slave (
    input  start_valid,
    input  row_start,
    input  row_end,
    input  threshold,
    input  in_spikes,
    input  mem_weight,
    input  mem_index,
    input  out_ready,
    output start_ready,
    output mem_addr,
    output out_valid,
    output out_sum,
    output out_spike,
    output busy
  );

endinterface

// File: rtl/sat_add.sv
// Combinational signed saturating add of an ACC_W accumulator and a W_W term.
module sat_add
  import snn_csr_pkg::*;
(
  input  logic signed [ACC_W-1:0] a_i,
  input  logic signed [W_W-1:0]   b_i,
  output logic signed [ACC_W-1:0] sum_o
);

  logic [ACC_W:0] wide;

  always_comb begin
    wide = {a_i[ACC_W-1], a_i} + {{(ACC_W + 1 - W_W) {b_i[W_W-1]}}, b_i};
    // Overflow iff the two top bits of the widened sum disagree.
    if (wide[ACC_W] != wide[ACC_W-1]) begin
      sum_o = wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      sum_o = wide[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/csr_row_accumulator.sv
// Walks one neuron's CSR weight range, sums the weights of spiking inputs with
// saturation and returns the sum plus a threshold-crossing flag.
module csr_row_accumulator
  import snn_csr_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  csr_row_accumulator_if.slave bus_io
);

  state_e                  state_q, state_d;
  logic [ADDR_W:0]         cur_q, cur_d;
  logic [ADDR_W:0]         end_q, end_d;
  logic signed [ACC_W-1:0] thr_q, thr_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic                    issue_q;

  logic                    row_empty;
  logic                    last_issue;
  logic                    hit;
  logic signed [ACC_W-1:0] acc_sum;

  assign row_empty  = bus_io.row_end <= {1'b0, bus_io.row_start};
  assign last_issue = cur_q == (end_q - (ADDR_W + 1)'(1));
  assign hit        = bus_io.in_spikes[bus_io.mem_index];

  sat_add u_sat_add (
    .a_i   (acc_q),
    .b_i   (bus_io.mem_weight),
    .sum_o (acc_sum)
  );

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    end_d   = end_q;
    thr_d   = thr_q;
    acc_d   = acc_q;
    addr_d  = addr_q;

    // Returned word pairs with the address issued in the previous cycle.
    if (issue_q && hit) begin
      acc_d = acc_sum;
    end

    unique case (state_q)
      StIdle: begin
        if (bus_io.start_valid) begin
          cur_d   = {1'b0, bus_io.row_start};
          end_d   = bus_io.row_end;
          thr_d   = bus_io.threshold;
          acc_d   = '0;
          state_d = row_empty ? StDone : StFetch;
        end
      end
      StFetch: begin
        addr_d = cur_q[ADDR_W-1:0];
        cur_d  = cur_q + (ADDR_W + 1)'(1);
        if (last_issue) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        state_d = StDone;
      end
      StDone: begin
        if (bus_io.out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cur_q   <= '0;
      end_q   <= '0;
      thr_q   <= '0;
      acc_q   <= '0;
      addr_q  <= '0;
      issue_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      end_q   <= end_d;
      thr_q   <= thr_d;
      acc_q   <= acc_d;
      addr_q  <= addr_d;
      issue_q <= (state_q == StFetch);
    end
  end

  // Outside FETCH the address holds its last issued value.
  assign bus_io.mem_addr    = (state_q == StFetch) ? cur_q[ADDR_W-1:0] : addr_q;
  assign bus_io.start_ready = (state_q == StIdle);
  assign bus_io.busy        = (state_q != StIdle);
  assign bus_io.out_valid   = (state_q == StDone);
  assign bus_io.out_sum     = acc_q;
  assign bus_io.out_spike   = (state_q == StDone) && (acc_q >= thr_q);

endmodule

// File: tb/tb_csr_row_accumulator.sv
// Scoreboard bench: rows are issued against a registered weight-memory model;
// a monitor compares each accepted result against a plain-arithmetic reference.
module tb_csr_row_accumulator;

  typedef struct {
    int sum;
    bit spike;
  } exp_t;

  logic clk;
  logic rst_n;

  csr_row_accumulator_if bus ();

  csr_row_accumulator dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  logic signed [7:0] mem_w [16384];
  logic [9:0]        mem_i [16384];
  logic signed [7:0] rd_w;
  logic [9:0]        rd_i;
  logic [1023:0]     spk;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   valid_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle-latency weight memory.
  always @(posedge clk) begin
    rd_w <= mem_w[bus.mem_addr];
    rd_i <= mem_i[bus.mem_addr];
  end

  assign bus.mem_weight = rd_w;
  assign bus.mem_index  = rd_i;
  assign bus.in_spikes  = spk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ref_sum(input int rs, input int re);
    int acc;
    acc = 0;
    for (int a = rs; a < re; a++) begin
      if (spk[mem_i[a]]) begin
        acc = acc + int'(mem_w[a]);
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
      end
    end
    return acc;
  endfunction

  // Monitor: compare once per result handshake.
  always @(negedge clk) begin
    #1;
    if (rst_n && bus.out_valid) begin
      valid_cnt++;
      if (bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_sum", int'(bus.out_sum), e.sum);
          chk("out_spike", longint'(bus.out_spike), longint'(e.spike));
        end
      end
    end
  end

  task automatic rand_spikes();
    for (int w = 0; w < 32; w++) spk[w*32 +: 32] = $urandom;
  endtask

  // Called and returns on a negedge; bp > 0 holds out_ready low for bp cycles.
  task automatic do_row(input int rs, input int re, input int thr, input int bp);
    int   n, exp_sum, exp_lat, lat;
    bit   seq_ok, stable_ok, hold_ok;
    logic [13:0] addr0;
    logic signed [15:0] s0;
    logic sp0;
    exp_t e;
    n       = (re > rs) ? re - rs : 0;
    exp_sum = ref_sum(rs, re);
    exp_lat = (n == 0) ? 1 : n + 2;
    e.sum   = exp_sum;
    e.spike = (exp_sum >= thr);
    exp_q.push_back(e);
    bus.out_ready   = (bp == 0);
    bus.row_start   = rs[13:0];
    bus.row_end     = re[14:0];
    bus.threshold   = thr[15:0];
    bus.start_valid = 1'b1;
    for (int i = 0; i < 100 && !bus.start_ready; i++) @(negedge clk);
    chk("start_accept", longint'(bus.start_ready), 1);
    addr0 = bus.mem_addr;
    @(negedge clk);
    bus.start_valid = 1'b0;
    lat = 1;
    seq_ok = 1'b1;
    while (!bus.out_valid && lat < 3000) begin
      if (lat <= n && int'(bus.mem_addr) != rs + lat - 1) seq_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, exp_lat);
    if (n > 0) chk("addr_sequence", longint'(seq_ok), 1);
    else chk("empty_addr_hold", longint'(bus.mem_addr), longint'(addr0));
    if (bp > 0) begin
      s0 = bus.out_sum;
      sp0 = bus.out_spike;
      stable_ok = 1'b1;
      hold_ok = 1'b1;
      for (int i = 0; i < bp; i++) begin
        if (i == 3) begin
          bus.row_start = 14'd0;
          bus.row_end = 15'd5;
          bus.start_valid = 1'b1;
        end
        if (i == 4) bus.start_valid = 1'b0;
        @(negedge clk);
        if (bus.out_sum != s0 || bus.out_spike != sp0) stable_ok = 1'b0;
        if (bus.start_ready || !bus.out_valid || !bus.busy) hold_ok = 1'b0;
      end
      chk("bp_stable", longint'(stable_ok), 1);
      chk("bp_hold", longint'(hold_ok), 1);
      bus.out_ready = 1'b1;
    end
    @(negedge clk);
    chk("back_to_idle", longint'(bus.start_ready), 1);
  endtask

  task automatic reset_mid_row();
    int vc;
    rand_spikes();
    bus.out_ready   = 1'b1;
    bus.row_start   = 14'd3000;
    bus.row_end     = 15'd3100;
    bus.threshold   = 16'sd0;
    bus.start_valid = 1'b1;
    for (int i = 0; i < 100 && !bus.start_ready; i++) @(negedge clk);
    @(negedge clk);
    bus.start_valid = 1'b0;
    repeat (40) @(negedge clk);
    chk("mid_row_busy", longint'(bus.busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", longint'(bus.out_valid), 0);
    chk("rst_busy", longint'(bus.busy), 0);
    chk("rst_start_ready", longint'(bus.start_ready), 1);
    chk("rst_out_sum", int'(bus.out_sum), 0);
    chk("rst_out_spike", longint'(bus.out_spike), 0);
    chk("rst_mem_addr", longint'(bus.mem_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    vc = valid_cnt;
    repeat (150) @(negedge clk);
    chk("no_valid_after_reset", valid_cnt, vc);
    chk("idle_after_reset", longint'(bus.start_ready), 1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int rs, re, len, thr;
    for (int a = 0; a < 16384; a++) begin
      mem_w[a] = 8'($urandom);
      mem_i[a] = 10'($urandom);
    end
    spk             = '0;
    bus.start_valid = 1'b0;
    bus.row_start   = '0;
    bus.row_end     = '0;
    bus.threshold   = '0;
    bus.out_ready   = 1'b1;
    rst_n           = 1'b0;
    @(negedge clk);
    #1;
    chk("reset_start_ready", longint'(bus.start_ready), 1);
    chk("reset_busy", longint'(bus.busy), 0);
    chk("reset_out_valid", longint'(bus.out_valid), 0);
    chk("reset_out_sum", int'(bus.out_sum), 0);
    chk("reset_out_spike", longint'(bus.out_spike), 0);
    chk("reset_mem_addr", longint'(bus.mem_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic row: 3 + 10 = 13 with threshold 13.
    mem_w[5] = 8'sd3;   mem_i[5] = 10'd2;
    mem_w[6] = -8'sd1;  mem_i[6] = 10'd7;
    mem_w[7] = 8'sd10;  mem_i[7] = 10'd9;
    spk = '0;
    spk[2] = 1'b1;
    spk[9] = 1'b1;
    do_row(5, 8, 13, 0);

    // Empty rows.
    do_row(20, 20, 5, 0);
    do_row(20, 10, -3, 0);

    // Saturation at both ends.
    for (int a = 1000; a < 1300; a++) mem_w[a] = 8'sd127;
    for (int a = 2000; a < 2300; a++) mem_w[a] = -8'sd128;
    spk = '1;
    do_row(1000, 1300, 0, 0);
    do_row(2000, 2300, -32768, 0);

    // Backpressure, then a request straight after release.
    rand_spikes();
    do_row(400, 410, 0, 10);
    do_row(500, 506, -50, 0);

    // Top of the address space.
    rand_spikes();
    do_row(16380, 16384, 0, 0);

    reset_mid_row();

    for (int k = 0; k < 25; k++) begin
      rand_spikes();
      rs  = $urandom_range(16000, 3);
      len = $urandom_range(40, 0);
      re  = ($urandom_range(7, 0) == 0) ? rs - $urandom_range(3, 0) : rs + len;
      thr = $urandom_range(400, 0) - 200;
      do_row(rs, re, thr, (k % 5 == 4) ? $urandom_range(6, 1) : 0);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
